fft16_stage_sequencer: RTL and testbench

- Frame-level controller for the 16-point radix-2 FFT.
- Accepts one 16-sample complex frame through a valid/ready handshake and holds it in an internal frame buffer.
- Runs the frame through one shared external butterfly-stage datapath four times, once per round, selecting the round with `stage_sel` and writing each round's result back into the buffer.
- Presents the finished frame on a valid/ready output port; it sits between the sample source and the FFT output consumer.

---
 rtl/fft16_stage_sequencer.sv | 115 +++++++++++
 tb/tb_fft16_stage_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_stage_sequencer.sv
// Frame controller for a 16-point radix-2 FFT: buffers one frame, runs it through
// four rounds of an external butterfly datapath, then presents it. Option: FFT16_SEQ_BITREV_EN.
module fft16_stage_sequencer #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned STAGE_LAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH*16-1:0] in_real,
    input  logic [DATA_WIDTH*16-1:0] in_imag,
    output logic [1:0]               stage_sel,
    output logic [DATA_WIDTH*16-1:0] stage_x_real,
    output logic [DATA_WIDTH*16-1:0] stage_x_imag,
    input  logic [DATA_WIDTH*16-1:0] stage_y_real,
    input  logic [DATA_WIDTH*16-1:0] stage_y_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH*16-1:0] out_real,
    output logic [DATA_WIDTH*16-1:0] out_imag,
    output logic                     busy
);

    localparam int unsigned FW     = DATA_WIDTH * 16;
    localparam logic [3:0]  LatCnt = 4'(STAGE_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      stage_q, stage_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [FW-1:0]   buf_re_q, buf_re_d;
    logic [FW-1:0]   buf_im_q, buf_im_d;

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        wait_cnt_d = wait_cnt_q;
        buf_re_d   = buf_re_q;
        buf_im_d   = buf_im_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    buf_re_d   = in_real;
                    buf_im_d   = in_imag;
                    stage_d    = 2'd0;
                    wait_cnt_d = 4'd0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                // Datapath result is valid STAGE_LAT cycles into the round.
                if (wait_cnt_q == LatCnt) begin
                    buf_re_d   = stage_y_real;
                    buf_im_d   = stage_y_imag;
                    wait_cnt_d = 4'd0;
                    if (stage_q == 2'd3) begin
                        state_d = StDone;
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            stage_q    <= 2'd0;
            wait_cnt_q <= 4'd0;
            buf_re_q   <= '0;
            buf_im_q   <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            wait_cnt_q <= wait_cnt_d;
            buf_re_q   <= buf_re_d;
            buf_im_q   <= buf_im_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign stage_sel    = (state_q == StRun) ? stage_q : 2'd0;
    assign stage_x_real = buf_re_q;
    assign stage_x_imag = buf_im_q;

    for (genvar i = 0; i < 16; i++) begin : g_out
`ifdef FFT16_SEQ_BITREV_EN
        localparam int Src = ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
`else
        localparam int Src = i;
`endif
        assign out_real[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH] =
            buf_re_q[DATA_WIDTH*(16-Src)-1 -: DATA_WIDTH];
        assign out_imag[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH] =
            buf_im_q[DATA_WIDTH*(16-Src)-1 -: DATA_WIDTH];
    end

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Directed bench for fft16_stage_sequencer: one instance at STAGE_LAT=1, one at STAGE_LAT=3,
// each driven by a small datapath model (word + round+1, or identity).
module tb_fft16_stage_sequencer;

    localparam int DW = 20;
    localparam int FW = DW * 16;
`ifdef FFT16_SEQ_BITREV_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ident;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Instance a: STAGE_LAT=1
    logic          in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [1:0]    sel_a;
    logic [FW-1:0] in_re_a, in_im_a, x_re_a, x_im_a, y_re_a, y_im_a, out_re_a, out_im_a;
    // Instance b: STAGE_LAT=3
    logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [1:0]    sel_b;
    logic [FW-1:0] in_re_b, in_im_b, x_re_b, x_im_b, y_re_b, y_im_b, out_re_b, out_im_b;
    logic [FW-1:0] pb_re [3];
    logic [FW-1:0] pb_im [3];

    fft16_stage_sequencer #(.DATA_WIDTH(DW), .STAGE_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_real(in_re_a), .in_imag(in_im_a), .stage_sel(sel_a),
        .stage_x_real(x_re_a), .stage_x_imag(x_im_a),
        .stage_y_real(y_re_a), .stage_y_imag(y_im_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_real(out_re_a), .out_imag(out_im_a), .busy(busy_a)
    );

    fft16_stage_sequencer #(.DATA_WIDTH(DW), .STAGE_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_real(in_re_b), .in_imag(in_im_b), .stage_sel(sel_b),
        .stage_x_real(x_re_b), .stage_x_imag(x_im_b),
        .stage_y_real(y_re_b), .stage_y_imag(y_im_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_real(out_re_b), .out_imag(out_im_b), .busy(busy_b)
    );

    function automatic logic [FW-1:0] model(input logic [FW-1:0] x, input logic [1:0] sel,
                                            input logic id);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (id) r[DW*(16-i)-1 -: DW] = x[DW*(16-i)-1 -: DW];
            else    r[DW*(16-i)-1 -: DW] = x[DW*(16-i)-1 -: DW] + DW'(sel) + DW'(1);
        end
        return r;
    endfunction

    // Frame with word i = add + mul*idx, idx = i or bitrev4(i).
    function automatic logic [FW-1:0] mk(input int add, input int mul, input bit br);
        logic [FW-1:0] r;
        logic [3:0]    iv;
        logic [3:0]    idx;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            iv  = 4'(i);
            idx = br ? {iv[0], iv[1], iv[2], iv[3]} : iv;
            r[DW*(16-i)-1 -: DW] = DW'(add + mul * int'(idx));
        end
        return r;
    endfunction

    always @(posedge clk) begin
        y_re_a   <= model(x_re_a, sel_a, ident);
        y_im_a   <= model(x_im_a, sel_a, ident);
        pb_re[0] <= model(x_re_b, sel_b, ident);
        pb_im[0] <= model(x_im_b, sel_b, ident);
        pb_re[1] <= pb_re[0];
        pb_im[1] <= pb_im[0];
        pb_re[2] <= pb_re[1];
        pb_im[2] <= pb_im[1];
    end
    assign y_re_b = pb_re[2];
    assign y_im_b = pb_im[2];

    task automatic check_eq(input string tag, input logic [FW-1:0] got,
                            input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ident = 1'b0;
        in_valid_a = 1'b0; out_ready_a = 1'b0; in_re_a = '0; in_im_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_re_b = '0; in_im_b = '0;
        repeat (3) tick();

        check_eq("rst_in_ready", FW'(in_ready_a), FW'(1));
        check_eq("rst_out_valid", FW'(out_valid_a), FW'(0));
        check_eq("rst_busy", FW'(busy_a), FW'(0));
        rst_n = 1'b1;
        tick();
        check_eq("idle_in_ready", FW'(in_ready_a), FW'(1));
        check_eq("idle_out_valid", FW'(out_valid_a), FW'(0));
        check_eq("idle_busy", FW'(busy_a), FW'(0));
        check_eq("idle_sel", FW'(sel_a), FW'(0));
        check_eq("idle_out_re", out_re_a, '0);
        check_eq("idle_out_im", out_im_a, '0);
        check_eq("idle_x_re", x_re_a, '0);

        // Round sequencing: zero frame, each round adds round+1 -> 10 everywhere
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("seq_sel_%0d", k), FW'(sel_a), FW'(k / 2));
            check_eq($sformatf("seq_busy_%0d", k), FW'(busy_a), FW'(1));
            check_eq($sformatf("seq_ovalid_%0d", k), FW'(out_valid_a), FW'(0));
            tick();
        end
        check_eq("seq_out_valid", FW'(out_valid_a), FW'(1));
        check_eq("seq_out_re", out_re_a, mk(10, 0, 1'b0));
        check_eq("seq_out_im", out_im_a, mk(10, 0, 1'b0));

        // Backpressure with a competing input frame
        in_re_a = mk(0, 1, 1'b0);
        in_valid_a = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check_eq("bp_out_re", out_re_a, mk(10, 0, 1'b0));
            check_eq("bp_in_ready", FW'(in_ready_a), FW'(0));
            check_eq("bp_out_valid", FW'(out_valid_a), FW'(1));
            tick();
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        check_eq("bp_release_in_ready", FW'(in_ready_a), FW'(1));
        check_eq("bp_release_busy", FW'(busy_a), FW'(0));

        // Reset mid-run at T+4
        in_re_a = mk(0, 1, 1'b0);
        in_im_a = mk(32, 1, 1'b0);
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (3) tick();
        check_eq("mid_busy_before", FW'(busy_a), FW'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_in_ready", FW'(in_ready_a), FW'(1));
        check_eq("mid_busy", FW'(busy_a), FW'(0));
        check_eq("mid_sel", FW'(sel_a), FW'(0));
        check_eq("mid_x_re", x_re_a, '0);
        check_eq("mid_out_im", out_im_a, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh frame after reset: word i -> i+10 (imag 32+i -> 42+i)
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (7) tick();
        check_eq("fresh_not_yet", FW'(out_valid_a), FW'(0));
        tick();
        check_eq("fresh_out_valid", FW'(out_valid_a), FW'(1));
        check_eq("fresh_out_re", out_re_a, mk(10, 1, BR));
        check_eq("fresh_out_im", out_im_a, mk(42, 1, BR));
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;

        // Latency scaling on the STAGE_LAT=3 instance
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("lat3_sel_%0d", k), FW'(sel_b), FW'(k / 4));
            check_eq($sformatf("lat3_ovalid_%0d", k), FW'(out_valid_b), FW'(0));
            tick();
        end
        check_eq("lat3_out_valid", FW'(out_valid_b), FW'(1));
        check_eq("lat3_out_re", out_re_b, mk(10, 0, 1'b0));
        check_eq("lat3_out_im", out_im_b, mk(10, 0, 1'b0));
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        check_eq("lat3_in_ready", FW'(in_ready_b), FW'(1));

        // Output ordering with identity datapath
        ident = 1'b1;
        in_re_a = mk(0, 1, 1'b0);
        in_im_a = mk(32, 1, 1'b0);
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (8) tick();
        check_eq("order_out_valid", FW'(out_valid_a), FW'(1));
        check_eq("order_out_re", out_re_a, mk(0, 1, BR));
        check_eq("order_out_im", out_im_a, mk(32, 1, BR));
        check_eq("order_x_re", x_re_a, mk(0, 1, 1'b0));
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
